// File: rtl/instr_decode_stage_if.sv
// Purpose : fetch-side and decode-side stream signals of the RV32I decode stage.
// Latency : none, this is wiring only.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
//
// Ports (as seen by the stage, modport slave):
//   in_valid, in_instr, in_pc, out_ready                  inputs
//   in_ready, out_valid, CODE, rd, rs1, rs2, funct3,
//   funct7b5, imm, pc, illegal                            outputs
// The master modport is the environment's view (fetch + downstream).
interface instr_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      CODE;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, CODE, rd, rs1, rs2, funct3, funct7b5,
               imm, pc, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, CODE, rd, rs1, rs2, funct3, funct7b5,
               imm, pc, illegal
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Purpose : RV32I decode stage: opcode -> one-hot CODE, register fields, sign-extended imm.
// Latency : 1 cycle (accepted at edge N, out_valid after edge N).
// Backpressure: 2-entry skid buffer; in_ready is a register, low only while both entries are full.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   flush  synchronous discard of all buffered entries and of the input accepted that cycle
//   bus    instr_decode_stage_if.slave: fetch handshake (in_*) and decoded record (out_*)
module instr_decode_stage (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [9:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

    state_t   state_q, state_d;
    dec_t     main_q, skid_q;
    dec_t     dec_in;
    imm_sel_t imm_sel;
    logic     in_ready_q;
    logic     acc, pop;
    logic     ld_main_in, ld_main_skid, ld_skid;
    logic [31:0] ins;

    assign ins = bus.in_instr;

    // ---------------- combinational decode of the incoming instruction ----------------
    always_comb begin
        dec_in          = '0;
        imm_sel         = IMM_NONE;
        dec_in.rd       = ins[11:7];
        dec_in.rs1      = ins[19:15];
        dec_in.rs2      = ins[24:20];
        dec_in.funct3   = ins[14:12];
        dec_in.funct7b5 = ins[30];
        dec_in.pc       = bus.in_pc;

        case (ins[6:0])
            7'b1101111: begin dec_in.code = 10'b00_0000_0001; imm_sel = IMM_J; end
            7'b1100111: begin dec_in.code = 10'b00_0000_0010; imm_sel = IMM_I; end
            7'b0110111: begin dec_in.code = 10'b00_0000_0100; imm_sel = IMM_U; end
            7'b0010111: begin dec_in.code = 10'b00_0000_1000; imm_sel = IMM_U; end
            7'b1100011: begin dec_in.code = 10'b00_0001_0000; imm_sel = IMM_B; end
            7'b0110011: begin dec_in.code = 10'b00_0010_0000; end
            7'b0100011: begin dec_in.code = 10'b00_0100_0000; imm_sel = IMM_S; end
            7'b0010011: begin dec_in.code = 10'b00_1000_0000; imm_sel = IMM_I; end
            7'b0000011: begin dec_in.code = 10'b01_0000_0000; imm_sel = IMM_I; end
            7'b1110011: begin dec_in.code = 10'b10_0000_0000; imm_sel = IMM_I; end
            // FENCE is passed on as a NOP: no type bit, not illegal, no immediate.
            7'b0001111: begin end
            default:    dec_in.illegal = 1'b1;
        endcase

        case (imm_sel)
            IMM_I:   dec_in.imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   dec_in.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   dec_in.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   dec_in.imm = {ins[31:12], 12'b0};
            IMM_J:   dec_in.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: dec_in.imm = 32'd0;
        endcase
    end

    // ---------------- skid buffer control ----------------
    assign acc = bus.in_valid & in_ready_q;
    assign pop = (state_q != EMPTY) & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            // Loads stay off so the flush-cycle input never reaches a register.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        ld_main_in = 1'b1;
                    end else if (acc) begin
                        state_d = TWO;
                        ld_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (ld_main_in) begin
                main_q <= dec_in;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= dec_in;
            end
        end
    end

    // ---------------- outputs: always the head (main) entry ----------------
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.CODE      = main_q.code;
    assign bus.rd        = main_q.rd;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.funct3    = main_q.funct3;
    assign bus.funct7b5  = main_q.funct7b5;
    assign bus.imm       = main_q.imm;
    assign bus.pc        = main_q.pc;
    assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed vector table, hand-written
// backpressure / flush / async-reset sequences, then randomized traffic
// checked against a queue-based reference model.
module tb_instr_decode_stage;

    logic clk;
    logic reset;
    logic flush;

    instr_decode_stage_if #(.XLEN(32)) bus_if ();

    instr_decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [9:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
        logic        fence;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [9:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
        logic        chk_imm;
    } vec_t;

    // Opcode order = CODE bit position; entry 10 is FENCE.
    logic [6:0] ops [11] = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h63, 7'h33,
                             7'h23, 7'h13, 7'h03, 7'h73, 7'h0F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode written as arithmetic on the instruction fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        int   idx;
        int   v;
        e     = '0;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3  = ins[14:12];
        e.f7  = ins[30];
        e.pc  = p;
        idx   = -1;
        v     = 0;
        for (int k = 0; k < 11; k++) if (ins[6:0] == ops[k]) idx = k;
        if (idx < 0) begin
            e.ill = 1'b1;
        end else if (idx == 10) begin
            e.fence = 1'b1;
        end else begin
            e.code = 10'(1 << idx);
            case (idx)
                0:       v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                             + int'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
                4:       v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                             + int'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
                6:       v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
                1, 7, 8, 9: v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
                2, 3:    v = int'(ins & 32'hFFFF_F000);
                default: v = 0;
            endcase
            e.imm = 32'(v);
        end
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".CODE"},     32'(bus_if.CODE),     32'(e.code));
        chk({tag, ".rd"},       32'(bus_if.rd),       32'(e.rd));
        chk({tag, ".rs1"},      32'(bus_if.rs1),      32'(e.rs1));
        chk({tag, ".rs2"},      32'(bus_if.rs2),      32'(e.rs2));
        chk({tag, ".funct3"},   32'(bus_if.funct3),   32'(e.f3));
        chk({tag, ".funct7b5"}, 32'(bus_if.funct7b5), 32'(e.f7));
        if (!e.fence) chk({tag, ".imm"}, bus_if.imm, e.imm);
        chk({tag, ".pc"},       bus_if.pc,            e.pc);
        chk({tag, ".illegal"},  32'(bus_if.illegal),  32'(e.ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        bus_if.in_valid = v;
        bus_if.in_instr = ins;
        bus_if.in_pc    = p;
    endtask

    vec_t vt [9];
    exp_t q [$];
    exp_t head;

    initial begin
        reset            = 1'b0;
        flush            = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        vt[0] = '{32'h0050_0093, 32'h100, 10'h080, 5'd1,  5'd0, 5'd5, 32'h0000_0005, 1'b0, 1'b1};
        vt[1] = '{32'h0080_00EF, 32'h104, 10'h001, 5'd1,  5'd0, 5'd8, 32'h0000_0008, 1'b0, 1'b1};
        vt[2] = '{32'hFE00_0EE3, 32'h108, 10'h010, 5'd29, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b1};
        vt[3] = '{32'h0020_A223, 32'h10C, 10'h040, 5'd4,  5'd1, 5'd2, 32'h0000_0004, 1'b0, 1'b1};
        vt[4] = '{32'h1234_52B7, 32'h110, 10'h004, 5'd5,  5'd8, 5'd3, 32'h1234_5000, 1'b0, 1'b1};
        vt[5] = '{32'hFFFF_FFFF, 32'h114, 10'h000, 5'd31, 5'd31, 5'd31, 32'h0, 1'b1, 1'b1};
        vt[6] = '{32'h0000_000F, 32'h118, 10'h000, 5'd0,  5'd0, 5'd0, 32'h0, 1'b0, 1'b0};
        vt[7] = '{32'h0020_81B3, 32'h11C, 10'h020, 5'd3,  5'd1, 5'd2, 32'h0, 1'b0, 1'b1};
        vt[8] = '{32'h0000_0073, 32'h120, 10'h200, 5'd0,  5'd0, 5'd0, 32'h0, 1'b0, 1'b1};

        // ---- reset values ----
        #12;
        chk("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("rst.CODE",      32'(bus_if.CODE),      32'd0);
        chk("rst.illegal",   32'(bus_if.illegal),   32'd0);
        chk("rst.imm",       bus_if.imm,            32'd0);
        chk("rst.pc",        bus_if.pc,             32'd0);
        chk("rst.rd",        32'(bus_if.rd),        32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---- directed vector table ----
        foreach (vt[i]) begin
            @(negedge clk);
            drive(1'b1, vt[i].instr, vt[i].pc);
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0);
            chk($sformatf("vec%0d.out_valid", i), 32'(bus_if.out_valid), 32'd1);
            chk($sformatf("vec%0d.CODE", i),      32'(bus_if.CODE),      32'(vt[i].code));
            chk($sformatf("vec%0d.rd", i),        32'(bus_if.rd),        32'(vt[i].rd));
            chk($sformatf("vec%0d.rs1", i),       32'(bus_if.rs1),       32'(vt[i].rs1));
            chk($sformatf("vec%0d.rs2", i),       32'(bus_if.rs2),       32'(vt[i].rs2));
            if (vt[i].chk_imm) chk($sformatf("vec%0d.imm", i), bus_if.imm, vt[i].imm);
            chk($sformatf("vec%0d.pc", i),        bus_if.pc,             vt[i].pc);
            chk($sformatf("vec%0d.illegal", i),   32'(bus_if.illegal),   32'(vt[i].ill));
        end
        @(negedge clk);
        chk("vec.drain.out_valid", 32'(bus_if.out_valid), 32'd0);

        // ---- backpressure: A, B accepted, C stalled, then drained in order ----
        bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h200);
        @(negedge clk);
        chk("bp.one.out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("bp.one.in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("bp.one.pc",        bus_if.pc,             32'h200);
        drive(1'b1, 32'h0020_81B3, 32'h204);
        @(negedge clk);
        chk("bp.two.in_ready",  32'(bus_if.in_ready),  32'd0);
        chk("bp.two.pc",        bus_if.pc,             32'h200);
        drive(1'b1, 32'h1234_52B7, 32'h208);
        @(negedge clk);
        chk("bp.stall.in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("bp.hold.pc",        bus_if.pc,            32'h200);
        chk("bp.hold.CODE",      32'(bus_if.CODE),     32'h080);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.popA.pc",       bus_if.pc,             32'h204);
        chk("bp.popA.CODE",     32'(bus_if.CODE),      32'h020);
        chk("bp.popA.in_ready", 32'(bus_if.in_ready),  32'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        chk("bp.popB.pc",       bus_if.pc,             32'h208);
        chk("bp.popB.CODE",     32'(bus_if.CODE),      32'h004);
        chk("bp.popB.out_valid", 32'(bus_if.out_valid), 32'd1);
        @(negedge clk);
        chk("bp.empty.out_valid", 32'(bus_if.out_valid), 32'd0);

        // ---- flush while TWO with a new input present ----
        bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h300);
        @(negedge clk);
        drive(1'b1, 32'h0080_00EF, 32'h304);
        @(negedge clk);
        chk("fl.pre.in_ready", 32'(bus_if.in_ready), 32'd0);
        drive(1'b1, 32'h1234_52B7, 32'h308);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus_if.out_ready = 1'b1;
        chk("fl.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("fl.in_ready",  32'(bus_if.in_ready),  32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("fl.stay_empty", 32'(bus_if.out_valid), 32'd0);
        end

        // ---- asynchronous reset while ONE ----
        bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h0020_A223, 32'h400);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        chk("ar.pre.out_valid", 32'(bus_if.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("ar.in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("ar.pc",        bus_if.pc,             32'd0);
        chk("ar.CODE",      32'(bus_if.CODE),      32'd0);
        chk("ar.imm",       bus_if.imm,            32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---- randomized traffic against the queue model ----
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] r;
            logic [31:0] ins;
            logic [31:0] p;
            int          sel;
            logic        acc_m, pop_m, fl_m;
            @(negedge clk);
            chk("rnd.out_valid", 32'(bus_if.out_valid), 32'(q.size() > 0));
            chk("rnd.in_ready",  32'(bus_if.in_ready),  32'(q.size() < 2));
            if (q.size() > 0 && bus_if.out_valid) begin
                head = q[0];
                cmp_out("rnd", head);
            end
            sel = $urandom_range(0, 11);
            r   = $urandom();
            ins = (sel == 11) ? r : {r[31:7], ops[sel]};
            p   = $urandom() & 32'hFFFF_FFFC;
            drive($urandom_range(0, 3) != 0, ins, p);
            bus_if.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            acc_m = bus_if.in_valid && (q.size() < 2);
            pop_m = bus_if.out_ready && (q.size() > 0);
            fl_m  = flush;
            @(posedge clk);
            if (fl_m) begin
                q.delete();
            end else begin
                if (pop_m) void'(q.pop_front());
                if (acc_m) q.push_back(model(ins, p));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
